// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
// Address layout: [31 : LINE_LSB+index_bits] tag, [LINE_LSB+index_bits-1 : LINE_LSB] index, [LINE_LSB-1:2] word offset.
package icache_pkg;

    localparam int OFFSET_BITS    = 3;
    localparam int LINE_BITS      = 256;
    localparam int WORD_BITS      = 32;
    localparam int WORD_LSB       = 5;
    localparam int LINE_LSB       = OFFSET_BITS + 2;
    localparam int WORDS_PER_LINE = 1 << OFFSET_BITS;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } state_t;

    function automatic logic [OFFSET_BITS-1:0] addr_offset(input logic [31:0] addr);
        return OFFSET_BITS'((addr >> 2) & 32'(WORDS_PER_LINE - 1));
    endfunction

    function automatic logic [31:0] addr_index(input logic [31:0] addr, input int index_bits);
        return (addr >> LINE_LSB) & ((32'd1 << index_bits) - 32'd1);
    endfunction

    function automatic logic [31:0] addr_tag(input logic [31:0] addr, input int index_bits);
        return addr >> (LINE_LSB + index_bits);
    endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the instruction cache: one combinational read port,
// one line-wide write port, and a flush-all that loses to a fill of the same edge.
module icache_line_store
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 32,
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS   = 27 - INDEX_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [LINE_BITS-1:0]  rd_line,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [LINE_BITS-1:0]  wr_line
);

    logic [NUM_LINES-1:0] valid_q;
    logic [NUM_LINES-1:0] valid_d;
    logic [TAG_BITS-1:0]  tag_mem  [NUM_LINES];
    logic [LINE_BITS-1:0] data_mem [NUM_LINES];

    // A fill landing on the flush edge keeps its own line valid.
    always_comb begin
        valid_d = valid_q;
        if (flush) begin
            valid_d = '0;
        end
        if (wr_en) begin
            valid_d[wr_index] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_mem[wr_index]  <= wr_tag;
            data_mem[wr_index] <= wr_line;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_line  = data_mem[rd_index];

endmodule

// File: rtl/icache_direct_mapped.sv
// Direct-mapped instruction cache: same-cycle hits, stall plus whole-line block refill on a miss,
// and saturating hit/miss counters.
module icache_direct_mapped
    import icache_pkg::*;
#(
    parameter int NUM_LINES  = 32,
    parameter int INDEX_BITS = 5,
    parameter int TAG_BITS   = 27 - INDEX_BITS
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic [31:0]          Address_IN,
    output logic [31:0]          Instruction_OUT,
    output logic                 Stall_OUT,
    input  logic                 Flush_IN,
    output logic [31:0]          MemAddress_OUT,
    output logic                 MemBlockRead_OUT,
    input  logic [LINE_BITS-1:0] InstructionBlock_IN,
    input  logic                 BlockValid_IN,
    output logic [31:0]          HitCount_OUT,
    output logic [31:0]          MissCount_OUT
);

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    state_t                 state_q;
    state_t                 state_d;
    logic [31-LINE_LSB:0]   miss_addr_q;
    logic [31-LINE_LSB:0]   miss_addr_d;
    logic [31:0]            hit_cnt_q;
    logic [31:0]            hit_cnt_d;
    logic [31:0]            miss_cnt_q;
    logic [31:0]            miss_cnt_d;

    logic [INDEX_BITS-1:0]  lk_index;
    logic [TAG_BITS-1:0]    lk_tag;
    logic [OFFSET_BITS-1:0] lk_offset;
    logic [31:0]            miss_line_addr;
    logic [INDEX_BITS-1:0]  fill_index;
    logic [TAG_BITS-1:0]    fill_tag;
    logic                   rd_valid;
    logic [TAG_BITS-1:0]    rd_tag;
    logic [LINE_BITS-1:0]   rd_line;
    logic                   hit;
    logic                   fill;
    logic                   lookup;

    assign lk_index       = INDEX_BITS'(addr_index(Address_IN, INDEX_BITS));
    assign lk_tag         = TAG_BITS'(addr_tag(Address_IN, INDEX_BITS));
    assign lk_offset      = addr_offset(Address_IN);
    assign miss_line_addr = {miss_addr_q, {LINE_LSB{1'b0}}};
    assign fill_index     = INDEX_BITS'(addr_index(miss_line_addr, INDEX_BITS));
    assign fill_tag       = TAG_BITS'(addr_tag(miss_line_addr, INDEX_BITS));

    assign hit    = rd_valid && (rd_tag == lk_tag);
    // A reset edge aborts any refill in flight, so a late BlockValid_IN never writes.
    assign fill   = (state_q == MISS) && BlockValid_IN && !RESET;
    assign lookup = (state_q == IDLE) && !Flush_IN;

    icache_line_store #(
        .NUM_LINES (NUM_LINES),
        .INDEX_BITS(INDEX_BITS),
        .TAG_BITS  (TAG_BITS)
    ) u_line_store (
        .clk     (CLOCK),
        .rst     (RESET),
        .flush   (Flush_IN),
        .rd_index(lk_index),
        .rd_valid(rd_valid),
        .rd_tag  (rd_tag),
        .rd_line (rd_line),
        .wr_en   (fill),
        .wr_index(fill_index),
        .wr_tag  (fill_tag),
        .wr_line (InstructionBlock_IN)
    );

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
            hit_cnt_q   <= '0;
            miss_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
            hit_cnt_q   <= hit_cnt_d;
            miss_cnt_q  <= miss_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (lookup && !hit) begin
                    state_d = MISS;
                end
            end
            MISS: begin
                if (BlockValid_IN) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Only a real IDLE lookup counts; flush cycles and the fill cycle count as neither.
    always_comb begin
        miss_addr_d = miss_addr_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        if (lookup) begin
            if (hit) begin
                hit_cnt_d = sat_inc(hit_cnt_q);
            end else begin
                miss_cnt_d  = sat_inc(miss_cnt_q);
                miss_addr_d = Address_IN[31:LINE_LSB];
            end
        end
    end

    always_comb begin
        Stall_OUT        = 1'b0;
        Instruction_OUT  = '0;
        MemBlockRead_OUT = (state_q == MISS);
        if (!RESET) begin
            Instruction_OUT = rd_line[{lk_offset, {WORD_LSB{1'b0}}} +: WORD_BITS];
            case (state_q)
                IDLE:    Stall_OUT = Flush_IN || !hit;
                MISS:    Stall_OUT = 1'b1;
                default: Stall_OUT = 1'b1;
            endcase
        end
    end

    assign MemAddress_OUT = miss_line_addr;
    assign HitCount_OUT   = hit_cnt_q;
    assign MissCount_OUT  = miss_cnt_q;

endmodule

// File: tb/tb_icache_direct_mapped.sv
// Bench for icache_direct_mapped: directed scenarios followed by random fetch traffic,
// checked against a line-level model of cache contents and a synthetic instruction memory.
module tb_icache_direct_mapped;

    logic         CLOCK = 1'b0;
    logic         RESET;
    logic [31:0]  Address_IN;
    logic [31:0]  Instruction_OUT;
    logic         Stall_OUT;
    logic         Flush_IN;
    logic [31:0]  MemAddress_OUT;
    logic         MemBlockRead_OUT;
    logic [255:0] InstructionBlock_IN;
    logic         BlockValid_IN;
    logic [31:0]  HitCount_OUT;
    logic [31:0]  MissCount_OUT;

    always #5 CLOCK = ~CLOCK;

    icache_direct_mapped dut (
        .CLOCK              (CLOCK),
        .RESET              (RESET),
        .Address_IN         (Address_IN),
        .Instruction_OUT    (Instruction_OUT),
        .Stall_OUT          (Stall_OUT),
        .Flush_IN           (Flush_IN),
        .MemAddress_OUT     (MemAddress_OUT),
        .MemBlockRead_OUT   (MemBlockRead_OUT),
        .InstructionBlock_IN(InstructionBlock_IN),
        .BlockValid_IN      (BlockValid_IN),
        .HitCount_OUT       (HitCount_OUT),
        .MissCount_OUT      (MissCount_OUT)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    // Model: which memory line each of the 32 slots holds, plus expected counter values.
    bit          mv [32];
    logic [31:0] mt [32];
    int unsigned m_hits = 0;
    int unsigned m_miss = 0;
    logic [31:0] pool [4] = '{32'h0040_0000, 32'h0040_0400, 32'h1001_0000, 32'h7FFF_FC00};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0040_0000) return 32'h2008_0005;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    function automatic logic [255:0] mem_line(input logic [31:0] a);
        logic [255:0] l;
        logic [31:0]  base;
        base = a & ~32'h1F;
        for (int i = 0; i < 8; i++) l[32*i +: 32] = mem_word(base + 32'(i * 4));
        return l;
    endfunction

    task automatic tick();
        @(posedge CLOCK);
        #2;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mv[i] = 1'b0;
    endtask

    // Memory side of one refill for line tgt: BlockValid_IN on MISS cycle number wait_cyc.
    task automatic serve_miss(input logic [31:0] tgt, input int wait_cyc, input bit flush_fill,
                              input logic [31:0] nxt, inout int stalls);
        int idx;
        Address_IN = nxt;
        for (int c = 1; c <= wait_cyc; c++) begin
            if (c == wait_cyc) begin
                BlockValid_IN       = 1'b1;
                InstructionBlock_IN = mem_line(tgt);
                Flush_IN            = flush_fill;
            end
            #1;
            chk("stall_in_miss", Stall_OUT, 1);
            if (Stall_OUT) stalls++;
            chk("mbr_in_miss", MemBlockRead_OUT, 1);
            chk("mem_addr", MemAddress_OUT, tgt & ~32'h1F);
            tick();
        end
        BlockValid_IN = 1'b0;
        Flush_IN      = 1'b0;
        if (flush_fill) model_clear();
        idx     = int'((tgt >> 5) & 32'd31);
        mv[idx] = 1'b1;
        mt[idx] = tgt >> 10;
    endtask

    // Fetch addr until served; an optional redirect moves Address_IN during the first refill.
    task automatic fetch(input logic [31:0] addr, input int wait_cyc, input bit flush_fill,
                         input bit redir_en, input logic [31:0] redir, output int stalls);
        logic [31:0] cur;
        logic [31:0] tgt;
        int          idx;
        bit          done;
        cur    = addr;
        done   = 1'b0;
        stalls = 0;
        for (int it = 0; it < 3 && !done; it++) begin
            Address_IN    = cur;
            Flush_IN      = 1'b0;
            BlockValid_IN = 1'b0;
            #1;
            idx = int'((cur >> 5) & 32'd31);
            chk("mbr_idle", MemBlockRead_OUT, 0);
            if (mv[idx] && mt[idx] == (cur >> 10)) begin
                chk("stall_hit", Stall_OUT, 0);
                chk("insn", Instruction_OUT, mem_word(cur & ~32'h3));
                m_hits++;
                tick();
                done = 1'b1;
            end else begin
                chk("stall_lookup_miss", Stall_OUT, 1);
                if (Stall_OUT) stalls++;
                m_miss++;
                tgt = cur;
                tick();
                if (redir_en && it == 0) cur = redir;
                serve_miss(tgt, wait_cyc, flush_fill, cur, stalls);
            end
        end
        chk("fetch_done", 32'(done), 1);
        chk("hit_count", HitCount_OUT, m_hits);
        chk("miss_count", MissCount_OUT, m_miss);
    endtask

    task automatic flush_idle(input logic [31:0] addr);
        Address_IN    = addr;
        Flush_IN      = 1'b1;
        BlockValid_IN = 1'b0;
        #1;
        chk("stall_flush", Stall_OUT, 1);
        tick();
        Flush_IN = 1'b0;
        model_clear();
        chk("hit_count_flush", HitCount_OUT, m_hits);
        chk("miss_count_flush", MissCount_OUT, m_miss);
    endtask

    function automatic logic [31:0] rand_addr();
        return pool[$urandom_range(0, 3)] | (32'($urandom_range(0, 31)) << 5)
             | (32'($urandom_range(0, 7)) << 2);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        RESET               = 1'b1;
        Address_IN          = 32'h0040_0000;
        Flush_IN            = 1'b0;
        BlockValid_IN       = 1'b0;
        InstructionBlock_IN = '0;
        #1;
        chk("rst_stall", Stall_OUT, 0);
        chk("rst_insn", Instruction_OUT, 0);
        tick();
        tick();
        chk("rst_mbr", MemBlockRead_OUT, 0);
        chk("rst_mem_addr", MemAddress_OUT, 0);
        chk("rst_hits", HitCount_OUT, 0);
        chk("rst_misses", MissCount_OUT, 0);
        RESET = 1'b0;

        // Cold miss with immediate memory response, then the rest of the line.
        fetch(32'h0040_0000, 1, 1'b0, 1'b0, 32'h0, st);
        chk("t1_stall_cycles", st, 2);
        chk("t1_miss_count", MissCount_OUT, 1);
        for (int w = 1; w < 8; w++) fetch(32'h0040_0000 + 32'(w * 4), 1, 1'b0, 1'b0, 32'h0, st);
        chk("t2_hit_count", HitCount_OUT, 8);

        // Conflict on index 0.
        fetch(32'h0040_0000, 1, 1'b0, 1'b0, 32'h0, st);
        fetch(32'h0040_0400, 1, 1'b0, 1'b0, 32'h0, st);
        fetch(32'h0040_0000, 1, 1'b0, 1'b0, 32'h0, st);
        chk("t3_miss_count", MissCount_OUT, 3);

        // Slow memory.
        fetch(32'h1001_0040, 4, 1'b0, 1'b0, 32'h0, st);
        chk("t4_stall_cycles", st, 5);

        // Flush, refetch, and a flush on the fill edge.
        flush_idle(32'h0040_0000);
        fetch(32'h0040_0000, 2, 1'b0, 1'b0, 32'h0, st);
        fetch(32'h0040_0020, 2, 1'b1, 1'b0, 32'h0, st);
        fetch(32'h0040_0020, 1, 1'b0, 1'b0, 32'h0, st);
        fetch(32'h0040_0000, 1, 1'b0, 1'b0, 32'h0, st);

        // Redirect while a refill is outstanding.
        fetch(32'h7FFF_FC60, 2, 1'b0, 1'b1, 32'h1001_0084, st);

        // Reset in the second MISS cycle with BlockValid_IN arriving alongside and after it.
        Address_IN    = 32'h0080_0020;
        Flush_IN      = 1'b0;
        BlockValid_IN = 1'b0;
        #1;
        chk("t6_stall_lookup", Stall_OUT, 1);
        tick();
        #1;
        chk("t6_mbr_miss1", MemBlockRead_OUT, 1);
        tick();
        RESET               = 1'b1;
        BlockValid_IN       = 1'b1;
        InstructionBlock_IN = mem_line(32'h0080_0020);
        #1;
        chk("t6_stall_in_reset", Stall_OUT, 0);
        chk("t6_insn_in_reset", Instruction_OUT, 0);
        tick();
        RESET = 1'b0;
        #1;
        model_clear();
        m_hits = 0;
        m_miss = 0;
        chk("t6_mbr_after", MemBlockRead_OUT, 0);
        chk("t6_hits_after", HitCount_OUT, m_hits);
        chk("t6_misses_after", MissCount_OUT, m_miss);
        chk("t6_refetch_misses", Stall_OUT, 1);
        m_miss++;
        tick();
        st = 0;
        serve_miss(32'h0080_0020, 1, 1'b0, 32'h0080_0020, st);
        fetch(32'h0080_0020, 1, 1'b0, 1'b0, 32'h0, st);

        // Random traffic.
        for (int n = 0; n < 150; n++) begin
            int r;
            r = int'($urandom_range(0, 15));
            if (r == 0) flush_idle(rand_addr());
            else fetch(rand_addr(), int'($urandom_range(1, 4)), r == 1, r == 2, rand_addr(), st);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/icache_direct_mapped.md
Name: icache_direct_mapped

Overview:
Direct-mapped instruction cache between the IF stage fetch address and the instruction-memory block port. Hits return the 32-bit instruction in the same cycle. Misses assert a stall toward the hazard unit and run a 256-bit line refill over the block-read interface (MemBlockRead/InstructionBlock). Hit and miss counters are kept for the test bench.

Parameters:
NUM_LINES, 32, number of cache lines; power of two, minimum 2.
INDEX_BITS, 5, log2(NUM_LINES).
TAG_BITS, 22, 27 - INDEX_BITS (address bits [31:5+INDEX_BITS]).

Ports:
CLOCK  in  1  sole clock; all state updates on rising edge.
RESET  in  1  synchronous, active-high reset.
Address_IN  in  32  fetch address from IF; word-aligned, bits [1:0] ignored.
Instruction_OUT  out  32  instruction word; valid when Stall_OUT=0.
Stall_OUT  out  1  high while the fetch cannot be serviced; drives the IF/ID stall.
Flush_IN  in  1  invalidate all lines.
MemAddress_OUT  out  32  line-aligned refill address {addr[31:5],5'b0}.
MemBlockRead_OUT  out  1  block-read request; level, held until the fill.
InstructionBlock_IN  in  256  refill line; word i at bits [32i+31:32i].
BlockValid_IN  in  1  InstructionBlock_IN valid this cycle; sampled only in MISS.
HitCount_OUT  out  32  hits served; saturates at 0xFFFFFFFF.
MissCount_OUT  out  32  misses detected; saturates at 0xFFFFFFFF.

Behaviour:
- Address split:
  - offset = addr[4:2] (word within line)
  - index = addr[5+INDEX_BITS-1:5]
  - tag = addr[31:5+INDEX_BITS]
- Storage per line: valid bit, tag, 8x32 data.
- Reset, while RESET=1 and at the edge:
  - all valid bits cleared; state=IDLE
  - MemBlockRead_OUT=0, MemAddress_OUT=0
  - counters=0
  - Stall_OUT=0 and Instruction_OUT=0, forced combinationally while RESET=1
  - reset mid-MISS aborts the refill; MemBlockRead_OUT drops the next cycle; a late BlockValid_IN is ignored.
- FSM states: IDLE, MISS.
- IDLE:
  - hit = valid[index] & (tag match), evaluated combinationally.
  - On hit: Instruction_OUT = data[index][offset], Stall_OUT=0, HitCount_OUT increments.
  - On miss:
    - Stall_OUT=1 and MissCount_OUT increments, both in the same cycle.
    - Address_IN[31:5] is latched into miss_addr; next state MISS.
    - MemBlockRead_OUT=1 and MemAddress_OUT={miss_addr,5'b0} from the next cycle.
- MISS:
  - Stall_OUT=1 and MemBlockRead_OUT=1 throughout.
  - On an edge with BlockValid_IN=1, the line at miss_addr index is written (data, tag, valid=1), then next state IDLE.
  - MemBlockRead_OUT=0 the cycle after the fill.
  - The fill cycle itself does not count as a hit or a miss.
- Latency:
  - Hit: 0 cycles.
  - Miss with BlockValid_IN in the first MISS cycle: Stall_OUT high for 2 cycles, then a hit.
  - Each extra memory wait cycle adds 1 cycle.
- Address_IN changing during MISS (e.g. a redirect): the refill completes for miss_addr; IDLE then re-looks up the current Address_IN, which may miss again.
- Flush_IN:
  - All valid bits are cleared at the edge.
  - In IDLE, Stall_OUT=1 that cycle and no counter changes.
  - In MISS, the refill continues; if the fill lands in the same edge as the flush, the filled line ends valid and all others end invalid.
- Counters: 32-bit, saturating, never wrap; at most one increment per cycle.
- Conflict miss (same index, different tag): the old line is overwritten; no write-back, because the cache is read-only.

Decomposition:
- Shared package icache_pkg:
  - OFFSET_BITS=3, LINE_BITS=256, WORD_BITS=32
  - state typedef {IDLE, MISS}
  - functions: tag/index/offset extract.
- One sub-module, icache_line_store:
  - holds the valid/tag/data arrays
  - combinational read port
  - single write port, write-enable plus line
  - flush-all input with fill-wins-on-same-line priority.

Test Plan:
1. Reset, then fetch 0x00400000 with BlockValid_IN on the 1st MISS cycle, block word0=0x20080005 -> Stall_OUT 1,1,0; MemAddress_OUT=0x00400000; Instruction_OUT=0x20080005; MissCount_OUT=1.
2. After test 1, fetch 0x00400004..0x0040001C -> no stall, eight words returned in order, HitCount_OUT=8.
3. Conflict: fetch 0x00400000 then 0x00400400 (same index 0, different tag), then 0x00400000 again -> three misses, MissCount_OUT=3, correct data each time.
4. Memory wait: BlockValid_IN delayed 4 cycles -> Stall_OUT high 5 cycles; MemBlockRead_OUT held 1 throughout, dropping the cycle after the fill.
5. Flush_IN pulse after a cached line, then refetch 0x00400000 -> miss; a flush coinciding with the fill edge leaves that line valid (next fetch hits).
6. RESET asserted in the 2nd MISS cycle, then BlockValid_IN=1 -> MemBlockRead_OUT=0 next cycle, no fill, counters=0, the next fetch misses.
